// File: rtl/pixel_cache_pkg.sv
// pixel_cache_pkg
//   Shared definitions for the 3x3 pixel cache frame sequencer.
//   - state_t : sequencer states (IDLE, CLEAR, RUN, DRAIN, DONE)
//   - PIX_W   : pixel width in bits
//   - WIN_W   : width of the flattened 3x3 cache window
//   - col_w() / row_w() : counter widths for a given image width / height
package pixel_cache_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int PIX_W = 8;
  localparam int WIN_W = 72;

  // Width of a column index for an image n pixels wide (at least 1 bit).
  function automatic int col_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a row index for an image h rows tall (at least 1 bit).
  function automatic int row_w(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/pixel_cache_ctrl_module_raster.sv
// raster_counter_module
//   Row/column position of the next pixel in a raster scan of an N x H frame.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-low reset
//     en   : advance one pixel (column first, row on column wrap)
//     clr  : synchronous return to (0,0)
//     row  : row of the next pixel
//     col  : column of the next pixel
//     last : next pixel is the final one of the frame, (H-1, N-1)
module raster_counter_module
  import pixel_cache_pkg::*;
#(
  parameter int N = 32,
  parameter int H = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  output logic [row_w(H)-1:0] row,
  output logic [col_w(N)-1:0] col,
  output logic                last
);

  localparam int COL_W = col_w(N);
  localparam int ROW_W = row_w(H);

  // Raster position: column wraps at N-1 and carries into the row, which wraps at H-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row <= ROW_W'(0);
      col <= COL_W'(0);
    end else if (clr) begin
      row <= ROW_W'(0);
      col <= COL_W'(0);
    end else if (en) begin
      if (col == COL_W'(N - 1)) begin
        col <= COL_W'(0);
        if (row == ROW_W'(H - 1)) begin
          row <= ROW_W'(0);
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end else begin
      row <= row;
      col <= col;
    end
  end

  assign last = (row == ROW_W'(H - 1)) && (col == COL_W'(N - 1));

endmodule

// File: rtl/pixel_cache_ctrl_module.sv
// pixel_cache_ctrl_module
//   Frame sequencer for the 3x3 pixel cache (line-buffer window generator).
//   Accepts a raster pixel stream, drives the cache load strobe/data with no
//   added latency, and flags the cycles where the cache window holds a full
//   3x3 neighbourhood, holding the stream while the consumer stalls.
//   Ports:
//     clk, rst                  : clock, synchronous active-low reset
//     start_i                   : begin a frame (only honoured in IDLE)
//     pix_valid_i/pix_data_i    : input pixel stream
//     pix_ready_o               : pixel accepted this cycle when valid
//     cache_clr_o               : one-cycle clear to the cache at frame start
//     cache_load_o/cache_data_o : cache load strobe and data
//     win_valid_o/win_ready_i   : window handshake with the consumer
//     win_row_o/win_col_o       : centre coordinates of the flagged window
//     busy_o                    : high outside IDLE
//     done_o                    : one-cycle end-of-frame pulse
//   Optional (PIXEL_CACHE_FRAME_CHECK_EN defined):
//     pix_last_i                : end-of-frame marker from the source
//     frame_err_o               : sticky marker mismatch, cleared in CLEAR
module pixel_cache_ctrl_module
  import pixel_cache_pkg::*;
#(
  parameter int N = 32,
  parameter int H = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                pix_valid_i,
  input  logic [PIX_W-1:0]    pix_data_i,
`ifdef PIXEL_CACHE_FRAME_CHECK_EN
  input  logic                pix_last_i,
  output logic                frame_err_o,
`endif
  output logic                pix_ready_o,
  output logic                cache_clr_o,
  output logic                cache_load_o,
  output logic [PIX_W-1:0]    cache_data_o,
  output logic                win_valid_o,
  input  logic                win_ready_i,
  output logic [row_w(H)-1:0] win_row_o,
  output logic [col_w(N)-1:0] win_col_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int COL_W = col_w(N);
  localparam int ROW_W = row_w(H);

  state_t             state_r;
  logic               cache_clr_r;
  logic               busy_r;
  logic               done_r;
  logic               win_valid_r;
  logic [ROW_W-1:0]   win_row_r;
  logic [COL_W-1:0]   win_col_r;

  logic               pix_ready_s;
  logic               accept_s;
  logic               qualify_s;
  logic               counter_clr_s;
  logic [ROW_W-1:0]   row_s;
  logic [COL_W-1:0]   col_s;
  logic               last_s;

  raster_counter_module #(
    .N (N),
    .H (H)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .en   (accept_s),
    .clr  (counter_clr_s),
    .row  (row_s),
    .col  (col_s),
    .last (last_s)
  );

  // Handshake decode; a pending unaccepted window freezes the stream so the
  // cache contents stay put while the consumer stalls.
  always_comb begin
    pix_ready_s   = 1'b0;
    counter_clr_s = 1'b0;
    if (state_r == RUN) begin
      pix_ready_s = !win_valid_r || win_ready_i;
    end else begin
      pix_ready_s = 1'b0;
    end
    if (state_r == CLEAR) begin
      counter_clr_s = 1'b1;
    end else begin
      counter_clr_s = 1'b0;
    end
    accept_s  = pix_valid_i && pix_ready_s;
    // Columns 0 and 1 would pair pixels from two different rows, so only
    // c >= 2 (and r >= 2) completes a real neighbourhood.
    qualify_s = accept_s && (row_s >= ROW_W'(2)) && (col_s >= COL_W'(2));
  end

  // Frame sequencer: state plus the registered clear/busy/done strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      cache_clr_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cache_clr_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r     <= CLEAR;
            cache_clr_r <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          state_r <= RUN;
        end
        RUN: begin
          if (accept_s && last_s) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (win_valid_r && win_ready_i) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Window flag and centre: a qualifying accept wins over a consumer accept
  // in the same cycle, so back-to-back windows need no idle cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_valid_r <= 1'b0;
      win_row_r   <= ROW_W'(0);
      win_col_r   <= COL_W'(0);
    end else if (state_r == CLEAR) begin
      win_valid_r <= 1'b0;
      win_row_r   <= ROW_W'(0);
      win_col_r   <= COL_W'(0);
    end else if (qualify_s) begin
      win_valid_r <= 1'b1;
      win_row_r   <= row_s - ROW_W'(1);
      win_col_r   <= col_s - COL_W'(1);
    end else if (win_ready_i) begin
      win_valid_r <= 1'b0;
    end else begin
      win_valid_r <= win_valid_r;
    end
  end

`ifdef PIXEL_CACHE_FRAME_CHECK_EN
  logic frame_err_r;

  // Sticky end-of-frame marker check; it observes accepts but never steers them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err_r <= 1'b0;
    end else if (state_r == CLEAR) begin
      frame_err_r <= 1'b0;
    end else if (accept_s && (pix_last_i != last_s)) begin
      frame_err_r <= 1'b1;
    end else begin
      frame_err_r <= frame_err_r;
    end
  end

  assign frame_err_o = frame_err_r;
`endif

  // The cache captures on the accepting edge, so load/data are driven straight
  // from the handshake.
  assign pix_ready_o  = pix_ready_s;
  assign cache_load_o = accept_s;
  assign cache_data_o = accept_s ? pix_data_i : {PIX_W{1'b0}};
  assign cache_clr_o  = cache_clr_r;
  assign win_valid_o  = win_valid_r;
  assign win_row_o    = win_row_r;
  assign win_col_o    = win_col_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;

endmodule

// File: tb/tb_pixel_cache_ctrl_module.sv
// Scoreboard bench for pixel_cache_ctrl_module with a 4x4 frame.
// Stimulus pushes the expected loads and window centres into queues; a
// monitor pops them whenever the DUT loads the cache or hands over a window,
// and compares the window contents of a reference line buffer.
module tb_pixel_cache_ctrl_module;

  localparam int N    = 4;
  localparam int H    = 4;
  localparam int NPIX = N * H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic       pix_valid_i = 1'b0;
  logic [7:0] pix_data_i = 8'd0;
  logic       win_ready_i = 1'b1;
  logic       pix_ready_o;
  logic       cache_clr_o;
  logic       cache_load_o;
  logic [7:0] cache_data_o;
  logic       win_valid_o;
  logic [1:0] win_row_o;
  logic [1:0] win_col_o;
  logic       busy_o;
  logic       done_o;
`ifdef PIXEL_CACHE_FRAME_CHECK_EN
  logic       pix_last_i = 1'b0;
  logic       frame_err_o;
`endif

  pixel_cache_ctrl_module #(.N(N), .H(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pix_valid_i  (pix_valid_i),
    .pix_data_i   (pix_data_i),
`ifdef PIXEL_CACHE_FRAME_CHECK_EN
    .pix_last_i   (pix_last_i),
    .frame_err_o  (frame_err_o),
`endif
    .pix_ready_o  (pix_ready_o),
    .cache_clr_o  (cache_clr_o),
    .cache_load_o (cache_load_o),
    .cache_data_o (cache_data_o),
    .win_valid_o  (win_valid_o),
    .win_ready_i  (win_ready_i),
    .win_row_o    (win_row_o),
    .win_col_o    (win_col_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_load_q[$];
  int exp_win_q[$];
  // Pixel index whose accept completes each window, and that window's centre.
  int win_trig[4] = '{10, 11, 14, 15};
  int win_r[4]    = '{1, 1, 2, 2};
  int win_c[4]    = '{1, 2, 1, 2};
  logic [7:0] hist [0:2*N+2];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_win(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference cache: shift register of the most recent 2N+3 loads.
  function automatic logic [71:0] model_window();
    logic [71:0] w;
    w = 72'd0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        w[(2-dy)*24 + (2-dx)*8 +: 8] = hist[(2-dy)*N + (2-dx)];
    return w;
  endfunction

  // Expected 3x3 neighbourhood of centre (r,c) when pixel value = raster index.
  function automatic logic [71:0] exp_window(input int r, input int c);
    logic [71:0] w;
    w = 72'd0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        w[(2-dy)*24 + (2-dx)*8 +: 8] = 8'((r - 1 + dy) * N + (c - 1 + dx));
    return w;
  endfunction

  // Monitor: pops and compares on every window hand-over and every cache load.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (win_valid_o && win_ready_i) begin
        if (exp_win_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_window: got centre (%0d,%0d), expected none", win_row_o, win_col_o);
        end else begin
          e = exp_win_q.pop_front();
          check("win_row", int'(win_row_o), e / 16);
          check("win_col", int'(win_col_o), e % 16);
          check_win("win_data", model_window(), exp_window(e / 16, e % 16));
        end
      end
      if (cache_load_o) begin
        if (exp_load_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_load: got data %0d, expected none", cache_data_o);
        end else begin
          e = exp_load_q.pop_front();
          check("load_data", int'(cache_data_o), e);
        end
        for (int i = 2*N+2; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = cache_data_o;
      end
      if (cache_clr_o) begin
        for (int i = 0; i <= 2*N+2; i++) hist[i] = 8'd0;
      end
    end
  end

  // One frame (or the first stop_idx pixels of it), called at posedge+1 in IDLE.
  task automatic run_frame(input int stop_idx, input bit bubbles, input int stall_n,
                           input bit poke_start, input int last_idx);
    int idx = 0;
    int cyc = 0;
    int stall_left = stall_n;
    int poke = 0;
    int wait_n = 0;
    for (int i = 0; i < stop_idx; i++) exp_load_q.push_back(i);
    for (int k = 0; k < 4; k++)
      if (win_trig[k] < stop_idx) exp_win_q.push_back(win_r[k] * 16 + win_c[k]);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("clr_pulse", int'(cache_clr_o), 1);
    check("busy_start", int'(busy_o), 1);
    check("ready_in_clear", int'(pix_ready_o), 0);
    @(posedge clk); #1;
    check("clr_one_cycle", int'(cache_clr_o), 0);
`ifdef PIXEL_CACHE_FRAME_CHECK_EN
    check("frame_err_cleared", int'(frame_err_o), 0);
`endif
    while (idx < stop_idx && cyc < 400) begin
      if (poke == 1) begin
        check("start_ignored_clr", int'(cache_clr_o), 0);
        check("start_ignored_busy", int'(busy_o), 1);
        poke = 2;
      end
      start_i = 1'b0;
      if (poke_start && poke == 0 && idx == 5) begin
        start_i = 1'b1;
        poke = 1;
      end
      pix_valid_i = bubbles ? ((cyc % 2) == 0) : 1'b1;
      pix_data_i  = 8'(idx);
`ifdef PIXEL_CACHE_FRAME_CHECK_EN
      pix_last_i  = (idx == last_idx);
`endif
      win_ready_i = (stall_left > 0 && win_valid_o) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (!win_ready_i) begin
        check("stall_ready", int'(pix_ready_o), 0);
        check("stall_load", int'(cache_load_o), 0);
        check("stall_row", int'(win_row_o), 1);
        check("stall_col", int'(win_col_o), 1);
        stall_left--;
      end
      if (pix_valid_i && pix_ready_o) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid_i = 1'b0;
    start_i     = 1'b0;
    win_ready_i = 1'b1;
    if (cyc >= 400) begin
      total++; bad++;
      $display("FAIL stream_timeout: got %0d pixels, expected %0d", idx, stop_idx);
    end
    if (stall_n > 0) check("stall_cycles_used", stall_left, 0);
    if (stop_idx == NPIX) begin
      check("busy_drain", int'(busy_o), 1);
      check("done_early", int'(done_o), 0);
      while (!done_o && wait_n < 20) begin
        @(posedge clk); #1;
        wait_n++;
      end
      check("done_latency", wait_n, 1);
      @(posedge clk); #1;
      check("done_one_cycle", int'(done_o), 0);
      check("busy_idle", int'(busy_o), 0);
      check("loads_left", exp_load_q.size(), 0);
      check("windows_left", exp_win_q.size(), 0);
`ifdef PIXEL_CACHE_FRAME_CHECK_EN
      check("frame_err", int'(frame_err_o), (last_idx != NPIX - 1) ? 1 : 0);
`endif
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, int'(pix_ready_o), 0);
    check({tag, "_clr"},   int'(cache_clr_o), 0);
    check({tag, "_load"},  int'(cache_load_o), 0);
    check({tag, "_data"},  int'(cache_data_o), 0);
    check({tag, "_valid"}, int'(win_valid_o), 0);
    check({tag, "_row"},   int'(win_row_o), 0);
    check({tag, "_col"},   int'(win_col_o), 0);
    check({tag, "_busy"},  int'(busy_o), 0);
    check({tag, "_done"},  int'(done_o), 0);
  endtask

  initial begin
    for (int i = 0; i <= 2*N+2; i++) hist[i] = 8'd0;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
`ifdef PIXEL_CACHE_FRAME_CHECK_EN
    check("reset_frame_err", int'(frame_err_o), 0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    run_frame(NPIX, 1'b0, 0, 1'b0, NPIX - 1);   // nominal
    run_frame(NPIX, 1'b0, 5, 1'b0, NPIX - 1);   // back-pressure at first window
    run_frame(NPIX, 1'b1, 0, 1'b1, NPIX - 1);   // bubbles plus ignored start

    run_frame(7, 1'b0, 0, 1'b0, NPIX - 1);      // abandon after index 6
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    check("midreset_loads_left", exp_load_q.size(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame(NPIX, 1'b0, 0, 1'b0, NPIX - 1);   // full frame after reset

`ifdef PIXEL_CACHE_FRAME_CHECK_EN
    run_frame(NPIX, 1'b0, 0, 1'b0, 9);          // early end marker
    run_frame(NPIX, 1'b0, 0, 1'b0, NPIX - 1);   // clean frame clears the flag
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
